// File: rtl/tile_write_packer_if.sv
// Element-stream input and tile-write output bundle of the tile write packer.
// The master side feeds beats and observes writes; the slave side is the packer.
interface tile_write_packer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int TILE_WIDTH = 256,
    parameter int IN_ELEMS   = 8,
    parameter int SEL_W      = 1
);
    logic                             in_valid;
    logic [IN_ELEMS*DATA_WIDTH-1:0]   in_data;
    logic                             in_ready;
    logic                             wr_en;
    logic [TILE_WIDTH-1:0]            wr_data;
    logic [SEL_W-1:0]                 wr_buffer;
    logic                             rst_idx_en;
    logic [SEL_W-1:0]                 rst_idx_buffer;

    modport master (
        output in_valid, in_data,
        input  in_ready, wr_en, wr_data, wr_buffer, rst_idx_en, rst_idx_buffer
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, wr_en, wr_data, wr_buffer, rst_idx_en, rst_idx_buffer
    );
endinterface

// File: rtl/tile_write_packer.sv
// Packs a narrow element stream into zero-padded tiles and writes them into one
// buffer of the tile buffer file, rewinding that buffer's write pointer first.
module tile_write_packer #(
    parameter int DATA_WIDTH   = 8,
    parameter int TILE_ELEMS   = 32,
    parameter int TILE_WIDTH   = 256,
    parameter int IN_ELEMS     = 8,
    parameter int BUFFER_WIDTH = 8192,
    parameter int BUFFER_COUNT = 2,
    localparam int MAX_ELEMS   = BUFFER_WIDTH / DATA_WIDTH,
    localparam int SEL_W       = (BUFFER_COUNT > 1) ? $clog2(BUFFER_COUNT) : 1,
    localparam int LEN_W       = $clog2(MAX_ELEMS) + 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [SEL_W-1:0]     dest_buffer,
    input  logic [LEN_W-1:0]     num_elems,
    tile_write_packer_if.slave   bus,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);
    localparam int BEAT_W = IN_ELEMS * DATA_WIDTH;
    localparam int BEATS  = TILE_ELEMS / IN_ELEMS;
    localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [LEN_W-1:0] MAX_L     = LEN_W'(MAX_ELEMS);
    localparam logic [LEN_W-1:0] IN_L      = LEN_W'(IN_ELEMS);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic [2:0] {IDLE, INIT, FILL, EMIT, DONE} state_t;

    state_t                  state_q;
    logic [SEL_W-1:0]        dest_q;
    logic [LEN_W-1:0]        rem_q;
    logic [CNT_W-1:0]        beat_cnt_q;
    logic [TILE_WIDTH-1:0]   tile_q;
    logic [TILE_WIDTH-1:0]   wr_data_q;
    logic                    in_ready_q;
    logic                    wr_en_q;
    logic                    rst_idx_en_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    err_q;

    logic [LEN_W-1:0]        take;
    logic [LEN_W-1:0]        rem_next;
    logic [BEAT_W-1:0]       beat_masked;
    logic [TILE_WIDTH-1:0]   tile_next;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        take        = (rem_q > IN_L) ? IN_L : rem_q;
        rem_next    = rem_q - take;
        beat_masked = bus.in_data;
        for (int k = 0; k < IN_ELEMS; k++) begin
            if (LEN_W'(k) >= rem_q) beat_masked[k*DATA_WIDTH +: DATA_WIDTH] = '0;
        end
        tile_next = tile_q;
        tile_next[beat_cnt_q*BEAT_W +: BEAT_W] = beat_masked;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values; the tile register is reset too, so a padded lane is never stale.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            dest_q       <= '0;
            rem_q        <= '0;
            beat_cnt_q   <= '0;
            tile_q       <= '0;
            wr_data_q    <= '0;
            in_ready_q   <= 1'b0;
            wr_en_q      <= 1'b0;
            rst_idx_en_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            wr_en_q      <= 1'b0;
            rst_idx_en_q <= 1'b0;
            done_q       <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        dest_q <= dest_buffer;
                        rem_q  <= (num_elems > MAX_L) ? MAX_L : num_elems;
                        err_q  <= (num_elems > MAX_L);
                        busy_q <= 1'b1;
                        if (num_elems == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q      <= INIT;
                            rst_idx_en_q <= 1'b1;
                        end
                    end
                end
                INIT: begin
                    tile_q     <= '0;
                    beat_cnt_q <= '0;
                    in_ready_q <= 1'b1;
                    state_q    <= FILL;
                end
                FILL: begin
                    if (bus.in_valid) begin
                        tile_q     <= tile_next;
                        rem_q      <= rem_next;
                        beat_cnt_q <= beat_cnt_q + CNT_W'(1);
                        if (beat_cnt_q == LAST_BEAT || rem_next == '0) begin
                            in_ready_q <= 1'b0;
                            wr_en_q    <= 1'b1;
                            wr_data_q  <= tile_next;
                            state_q    <= EMIT;
                        end
                    end
                end
                EMIT: begin
                    if (rem_q == '0) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        tile_q     <= '0;
                        beat_cnt_q <= '0;
                        in_ready_q <= 1'b1;
                        state_q    <= FILL;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Buffer selects follow the latched job so they stay stable across the whole job.
    assign bus.in_ready       = in_ready_q;
    assign bus.wr_en          = wr_en_q;
    assign bus.wr_data        = wr_data_q;
    assign bus.wr_buffer      = dest_q;
    assign bus.rst_idx_en     = rst_idx_en_q;
    assign bus.rst_idx_buffer = dest_q;
    assign busy               = busy_q;
    assign done               = done_q;
    assign err                = err_q;
endmodule

// File: tb/tb_tile_write_packer.sv
// Scoreboard bench for tile_write_packer: jobs push expected tiles and rewinds,
// a negedge monitor pops and compares them as the DUT strobes them out.
module tb_tile_write_packer;
    localparam int SEL_W = 1;
    localparam int LEN_W = 11;

    typedef struct packed {
        logic [255:0] data;
        logic         sel;
    } wr_t;

    logic             clk = 1'b0;
    logic             reset_n = 1'b1;
    logic             start = 1'b0;
    logic [SEL_W-1:0] dest_buffer = '0;
    logic [LEN_W-1:0] num_elems = '0;
    logic             busy, done, err;

    tile_write_packer_if #(.DATA_WIDTH(8), .TILE_WIDTH(256), .IN_ELEMS(8), .SEL_W(SEL_W)) bus ();

    tile_write_packer #(
        .DATA_WIDTH(8), .TILE_ELEMS(32), .TILE_WIDTH(256), .IN_ELEMS(8),
        .BUFFER_WIDTH(8192), .BUFFER_COUNT(2)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .dest_buffer(dest_buffer),
        .num_elems(num_elems), .bus(bus), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int  cyc = 0;
    int  total = 0;
    int  bad = 0;
    int  start_cyc = 0;
    int  last_acc = 0;
    int  wr_cnt = 0;
    int  done_cnt = 0;
    int  done_cyc = 0;
    int  busy_cycles = 0;
    int  rdy_cycles = 0;
    logic [255:0] last_tile = '0;
    wr_t  exp_wr[$];
    logic exp_rst[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Monitor: compares every strobe the DUT presents against the scoreboard queues.
    always @(negedge clk) begin : monitor
        wr_t  w;
        logic e;
        if (reset_n) begin
            if (busy) busy_cycles++;
            if (bus.in_ready) rdy_cycles++;
            if (bus.rst_idx_en) begin
                if (exp_rst.size() == 0) check("rst_idx_unexpected", 1, 0);
                else begin
                    e = exp_rst.pop_front();
                    check("rst_idx_buffer", bus.rst_idx_buffer, e);
                    check("rst_idx_time", cyc, start_cyc + 1);
                end
            end
            if (bus.wr_en) begin
                wr_cnt++;
                if (exp_wr.size() == 0) check("wr_unexpected", 1, 0);
                else begin
                    w = exp_wr.pop_front();
                    check("wr_data", bus.wr_data, w.data);
                    check("wr_buffer", bus.wr_buffer, w.sel);
                    check("wr_time", cyc, last_acc + 1);
                    last_tile = w.data;
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    function automatic logic [63:0] make_beat(input int b, input int nc, input int base);
        logic [63:0] d;
        for (int k = 0; k < 8; k++) begin
            d[k*8 +: 8] = (b*8 + k < nc) ? 8'(b*8 + k + base) : 8'hFF;
        end
        return d;
    endfunction

    function automatic logic [255:0] make_tile(input int t, input int nc, input int base);
        logic [255:0] d;
        for (int j = 0; j < 32; j++) begin
            d[j*8 +: 8] = (t*32 + j < nc) ? 8'(t*32 + j + base) : 8'h00;
        end
        return d;
    endfunction

    task automatic send_beat(input logic [63:0] d, input int pre_gap);
        int budget = 50;
        bus.in_valid = 1'b0;
        repeat (pre_gap) @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        while (!bus.in_ready && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (budget == 0) check("beat_accept_timeout", 0, 1);
        last_acc = cyc;
        @(negedge clk);
    endtask

    task automatic check_outputs_zero();
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_wr_en", bus.wr_en, 0);
        check("rst_wr_data", bus.wr_data, 0);
        check("rst_wr_buffer", bus.wr_buffer, 0);
        check("rst_idx_en", bus.rst_idx_en, 0);
        check("rst_idx_buffer_zero", bus.rst_idx_buffer, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
    endtask

    task automatic run_job(input int n, input logic sel, input bit gaps, input int mid_start,
                           input int exp_busy, input int base);
        int  nc = (n > 1024) ? 1024 : n;
        int  d0;
        int  budget = 1000;
        logic exp_err = (n > 1024);
        wr_t w;
        for (int t = 0; t < (nc + 31) / 32; t++) begin
            w.data = make_tile(t, nc, base);
            w.sel  = sel;
            exp_wr.push_back(w);
        end
        if (nc > 0) exp_rst.push_back(sel);
        @(negedge clk);
        busy_cycles = 0;
        rdy_cycles  = 0;
        d0          = done_cnt;
        start       = 1'b1;
        dest_buffer = sel;
        num_elems   = LEN_W'(n);
        start_cyc   = cyc;
        @(negedge clk);
        start = 1'b0;
        check("err_after_start", err, exp_err);
        for (int b = 0; b < (nc + 7) / 8; b++) begin
            if (b == mid_start) begin
                bus.in_valid = 1'b0;
                start        = 1'b1;
                dest_buffer  = ~sel;
                num_elems    = LEN_W'(8);
                @(negedge clk);
                start = 1'b0;
            end
            send_beat(make_beat(b, nc, base), gaps ? int'($urandom_range(0, 2)) : 0);
        end
        bus.in_valid = 1'b0;
        while (done_cnt == d0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check("done_count", done_cnt - d0, 1);
        check("done_time", done_cyc, (nc > 0) ? last_acc + 2 : start_cyc + 1);
        check("err_at_done", err, exp_err);
        check("wr_data_hold", bus.wr_data, last_tile);
        check("wr_left_over", exp_wr.size(), 0);
        check("rst_left_over", exp_rst.size(), 0);
        if (exp_busy >= 0) check("busy_cycles", busy_cycles, exp_busy);
        if (nc == 0) check("ready_zero_job", rdy_cycles, 0);
        @(negedge clk);
        check("idle_after_done", busy, 0);
    endtask

    initial begin
        int w0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        #1 reset_n = 1'b0;
        repeat (2) @(negedge clk);
        check_outputs_zero();
        reset_n = 1'b1;

        run_job(64,   1'b1, 1'b0, -1, 12,  0);   // full rate, two tiles
        run_job(37,   1'b0, 1'b0, -1, -1,  0);   // partial last tile, padded lanes
        run_job(0,    1'b1, 1'b0, -1, 1,   0);   // zero-length job
        run_job(64,   1'b0, 1'b1, -1, -1,  0);   // in_valid gaps
        run_job(2000, 1'b1, 1'b0, -1, 162, 0);   // clamped to 1024, err set
        run_job(64,   1'b0, 1'b0, 2,  -1,  7);   // start mid-FILL ignored, err cleared

        // Reset after two beats of a job: everything returns to zero, nothing written.
        exp_rst.push_back(1'b1);
        @(negedge clk);
        start       = 1'b1;
        dest_buffer = 1'b1;
        num_elems   = LEN_W'(64);
        start_cyc   = cyc;
        @(negedge clk);
        start = 1'b0;
        send_beat(make_beat(0, 64, 5), 0);
        send_beat(make_beat(1, 64, 5), 0);
        bus.in_valid = 1'b0;
        w0 = wr_cnt;
        reset_n = 1'b0;
        #1;
        check_outputs_zero();
        repeat (3) @(negedge clk);
        check("wr_during_reset", wr_cnt, w0);
        last_tile = '0;
        reset_n = 1'b1;
        run_job(32, 1'b1, 1'b0, -1, 7, 3);       // fresh single-tile job after reset

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
